// File: rtl/id_instr_queue_sb.sv
`default_nettype none
// ============================================================================
// Module      : id_instr_queue_sb
// Description : Decode-front instruction queue with register busy scoreboard.
//               Fetched {PC, instr} pairs are buffered in a DEPTH-entry
//               circular FIFO. The head is offered to ID only when none of its
//               source/destination registers is waiting on a multi-cycle
//               producer.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - fetch handshake, in_pc/in_instr payload
//               flush               - discard all queued entries
//               ext_stall           - downstream freeze
//               head_*              - register usage decoded from out_instr
//               out_valid/out_ready - issue handshake, out_pc/out_instr head
//               hazard_stall        - head blocked by the scoreboard
//               count               - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module id_instr_queue_sb #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int LAT_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic                       flush,
    input  logic                       ext_stall,
    input  logic [4:0]                 head_rs,
    input  logic [4:0]                 head_rt,
    input  logic                       head_rs_used,
    input  logic                       head_rt_used,
    input  logic                       head_wr_en,
    input  logic [4:0]                 head_wr_reg,
    input  logic [LAT_W-1:0]           head_wr_lat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_instr,
    output logic                       hazard_stall,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth_cnt = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] r_pc_mem    [DEPTH];
    logic [DATA_W-1:0] r_instr_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic [LAT_W-1:0]  r_busy_cnt  [NREG];

    logic [31:0]       w_busy;
    logic              w_not_empty;
    logic              w_hazard;
    logic              w_enq;
    logic              w_deq;
    logic              w_sb_load;

    // Busy flags indexed by the 5-bit register field. Register 0 and any
    // index beyond NREG are never busy.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_busy
            if (gi != 0 && gi < NREG) begin : g_real
                assign w_busy[gi] = (r_busy_cnt[gi] != '0);
            end else begin : g_zero
                assign w_busy[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_not_empty  = (r_count != '0);
    assign w_hazard     = (head_rs_used & w_busy[head_rs]) |
                          (head_rt_used & w_busy[head_rt]) |
                          (head_wr_en   & w_busy[head_wr_reg]);

    // in_ready looks only at occupancy, never at out_ready, so a full
    // queue refuses input even in a cycle where the head issues.
    assign in_ready     = (r_count < c_depth_cnt) & ~flush;
    assign out_valid    = w_not_empty & ~w_hazard & ~ext_stall & ~flush;
    assign hazard_stall = w_not_empty & w_hazard & ~flush;

    assign w_enq        = in_valid & in_ready;
    assign w_deq        = out_valid & out_ready;
    assign w_sb_load    = w_deq & head_wr_en & (head_wr_reg != 5'd0);

    assign out_pc       = w_not_empty ? r_pc_mem[r_rptr]    : '0;
    assign out_instr    = w_not_empty ? r_instr_mem[r_rptr] : '0;
    assign count        = r_count;

    // Payload storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc_mem[r_wptr]    <= in_pc;
            r_instr_mem[r_wptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + 1'b1;
            if (w_deq) r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Counters keep running through flush and ext_stall: producers already
    // in flight complete regardless. A fresh load overrides the decrement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (rst) begin
                r_busy_cnt[i] <= '0;
            end else if (w_sb_load && (head_wr_reg == 5'(i))) begin
                r_busy_cnt[i] <= head_wr_lat;
            end else if (r_busy_cnt[i] != '0) begin
                r_busy_cnt[i] <= r_busy_cnt[i] - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_instr_queue_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_instr_queue_sb
// Description : Directed self-checking bench for id_instr_queue_sb.
//               Instruction encoding used by the bench decoder:
//               [31:26] tag, [25:21] rs, [20:16] rt, [15:11] wr_reg,
//               [5:3] lat, [2] wr_en, [1] rt_used, [0] rs_used.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_instr_queue_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        ext_stall = 1'b0;
    logic [4:0]  head_rs;
    logic [4:0]  head_rt;
    logic        head_rs_used;
    logic        head_rt_used;
    logic        head_wr_en;
    logic [4:0]  head_wr_reg;
    logic [2:0]  head_wr_lat;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        hazard_stall;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Decoder model: register usage comes straight from the head instruction.
    assign head_rs      = out_instr[25:21];
    assign head_rt      = out_instr[20:16];
    assign head_wr_reg  = out_instr[15:11];
    assign head_wr_lat  = out_instr[5:3];
    assign head_wr_en   = out_instr[2];
    assign head_rt_used = out_instr[1];
    assign head_rs_used = out_instr[0];

    id_instr_queue_sb #(
        .DEPTH (4),
        .DATA_W(32),
        .NREG  (32),
        .LAT_W (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .flush        (flush),
        .ext_stall    (ext_stall),
        .head_rs      (head_rs),
        .head_rt      (head_rt),
        .head_rs_used (head_rs_used),
        .head_rt_used (head_rt_used),
        .head_wr_en   (head_wr_en),
        .head_wr_reg  (head_wr_reg),
        .head_wr_lat  (head_wr_lat),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .hazard_stall (hazard_stall),
        .count        (count)
    );

    function automatic logic [31:0] mk(input logic [5:0] tag, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic rsu, input logic rtu,
                                       input logic wen, input logic [2:0] lat);
        return {tag, rs, rt, rd, 5'd0, lat, wen, rtu, rsu};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_hazard", 32'(hazard_stall), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);

        // ---------------- fill to DEPTH, then drain in order ----------------
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fill_in_ready", 32'(in_ready), 32'd1);
            push(32'h100 + 32'(4*k), mk(6'(k+1), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        end
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head_pc", out_pc, 32'h100);
        check("full_head_instr", out_instr, mk(6'd1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_pc", out_pc, 32'h100 + 32'(4*k));
            tick();
        end
        #1;
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid_empty", 32'(out_valid), 32'd0);

        // ---------------- steady stream across pointer wrap ----------------
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h200 + 32'(4*k);
            in_instr = mk(6'(k), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
            #1;
            if (k > 0) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_pc", out_pc, 32'h200 + 32'(4*(k-1)));
                check("stream_count", 32'(count), 32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("stream_last_pc", out_pc, 32'h224);
        tick();
        #1;
        check("stream_end_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // ---------------- load-use hazard: wr 8 lat 2, then rs=8 ----------------
        push(32'h300, mk(6'd1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 3'd2));
        push(32'h304, mk(6'd2, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0));
        out_ready = 1'b1;
        #1;
        check("ld_issue_valid", 32'(out_valid), 32'd1);
        tick();
        #1;
        check("ld_c1_hazard", 32'(hazard_stall), 32'd1);
        check("ld_c1_valid", 32'(out_valid), 32'd0);
        tick();
        #1;
        check("ld_c2_hazard", 32'(hazard_stall), 32'd1);
        check("ld_c2_count", 32'(count), 32'd1);
        tick();
        #1;
        check("ld_c3_valid", 32'(out_valid), 32'd1);
        check("ld_c3_hazard", 32'(hazard_stall), 32'd0);
        check("ld_c3_pc", out_pc, 32'h304);
        tick();
        out_ready = 1'b0;

        // ---------------- register 0 is never busy ----------------
        push(32'h400, mk(6'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'd3));
        push(32'h404, mk(6'd4, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0));
        out_ready = 1'b1;
        #1;
        check("r0_valid0", 32'(out_valid), 32'd1);
        tick();
        #1;
        check("r0_valid1", 32'(out_valid), 32'd1);
        check("r0_hazard1", 32'(hazard_stall), 32'd0);
        tick();
        #1;
        check("r0_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // ---------------- flush with same-cycle enqueue ----------------
        push(32'h500, mk(6'd5, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 3'd3));
        push(32'h504, mk(6'd6, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        push(32'h508, mk(6'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        push(32'h50C, mk(6'd8, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0));
        out_ready = 1'b1;
        tick();                              // producer of r9 issues, cnt=3
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h5F0;
        in_instr = mk(6'd9, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        #1;
        check("fl_count_before", 32'(count), 32'd3);
        check("fl_in_ready", 32'(in_ready), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_hazard", 32'(hazard_stall), 32'd0);
        tick();                              // cnt=2, queue emptied
        flush    = 1'b0;
        in_pc    = 32'h600;
        in_instr = mk(6'd10, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        #1;
        check("fl_count_after", 32'(count), 32'd0);
        check("fl_out_valid_after", 32'(out_valid), 32'd0);
        check("fl_out_pc_after", out_pc, 32'd0);
        tick();                              // consumer enqueued, cnt=1
        in_valid = 1'b0;
        #1;
        check("fl_sb_kept", 32'(hazard_stall), 32'd1);
        check("fl_count_one", 32'(count), 32'd1);
        tick();                              // cnt=0
        #1;
        check("fl_sb_done_valid", 32'(out_valid), 32'd1);
        check("fl_sb_done_pc", out_pc, 32'h600);
        tick();
        out_ready = 1'b0;

        // ---------------- ext_stall while reg 5 is busy ----------------
        push(32'h700, mk(6'd11, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 3'd3));
        push(32'h704, mk(6'd12, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 3'd0));
        out_ready = 1'b1;
        tick();                              // producer issues, cnt5=3
        ext_stall = 1'b1;
        #1;
        check("es_valid", 32'(out_valid), 32'd0);
        check("es_hazard", 32'(hazard_stall), 32'd1);
        tick();
        tick();
        tick();                              // cnt5 has run down to 0
        ext_stall = 1'b0;
        #1;
        check("es_release_valid", 32'(out_valid), 32'd1);
        check("es_release_hazard", 32'(hazard_stall), 32'd0);
        tick();
        #1;
        check("es_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // ---------------- reset mid-stall clears scoreboard ----------------
        push(32'h800, mk(6'd13, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 3'd7));
        push(32'h804, mk(6'd14, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0));
        out_ready = 1'b1;
        tick();                              // cnt7=7
        #1;
        check("rs_stall", 32'(hazard_stall), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rs_count", 32'(count), 32'd0);
        check("rs_hazard", 32'(hazard_stall), 32'd0);
        push(32'h900, mk(6'd15, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0));
        #1;
        check("rs_dep_valid", 32'(out_valid), 32'd1);
        check("rs_dep_pc", out_pc, 32'h900);
        tick();
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
